// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: after a run, walks PC, cycle count, register bank
// and data memory, and streams each word LSB-first as UART frames.
//
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   i_start                        one-cycle dump request (ignored while busy)
//   i_pc, i_clk_count              core PC and executed-cycle counter
//   i_data_register, i_data_mem    combinational reads at the select addresses
//   i_tx_done                      UART frame-finished pulse
//   o_select_addr_registers        register bank read address
//   o_select_addr_memdata          data memory read address
//   o_tx_start, o_tx_data          UART request pulse and frame byte
//   o_busy, o_done                 dump in progress / one-cycle completion pulse
module debug_dump_sequencer #(
    parameter int BITS_SIZE   = 32,
    parameter int SIZE_TRAMA  = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [BITS_SIZE-1:0]           i_pc,
    input  logic [BITS_SIZE-1:0]           i_clk_count,
    input  logic [BITS_SIZE-1:0]           i_data_register,
    input  logic [BITS_SIZE-1:0]           i_data_mem,
    input  logic                           i_tx_done,
    output logic [$clog2(N_REGS)-1:0]      o_select_addr_registers,
    output logic [$clog2(N_MEM_WORDS)-1:0] o_select_addr_memdata,
    output logic                           o_tx_start,
    output logic [SIZE_TRAMA-1:0]          o_tx_data,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int N_WORDS = 2 + N_REGS + N_MEM_WORDS;
    localparam int IW      = $clog2(N_WORDS);
    localparam int AR      = $clog2(N_REGS);
    localparam int AM      = $clog2(N_MEM_WORDS);
    localparam int NB      = BITS_SIZE / SIZE_TRAMA;
    localparam int BW      = $clog2(NB);

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_WORDS - 1);
    localparam logic [IW-1:0] REG_BASE  = IW'(2);
    localparam logic [IW-1:0] MEM_BASE  = IW'(2 + N_REGS);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          idx_n;
    logic [BW-1:0]          byte_cnt;
    logic [BITS_SIZE-1:0]   shift;
    logic [BITS_SIZE-1:0]   src;
    logic [IW-1:0]          reg_off;
    logic [IW-1:0]          mem_off;
    logic [AR-1:0]          addr_r;
    logic [AM-1:0]          addr_m;

    logic                   tx_start_n;
    logic [SIZE_TRAMA-1:0]  tx_data_n;
    logic                   busy_n;
    logic                   done_n;
    logic [AR-1:0]          sel_r_n;
    logic [AM-1:0]          sel_m_n;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (i_start) state_n = SELECT;
            SELECT:  state_n = LOAD;
            LOAD:    state_n = SEND;
            SEND:    state_n = WAIT;
            WAIT:    if (i_tx_done) state_n = NEXT;
            NEXT: begin
                if (byte_cnt < LAST_BYTE) begin
                    state_n = SEND;
                end else if (idx < LAST_IDX) begin
                    state_n = SELECT;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Word index for the upcoming SELECT; addresses are derived from it so
    // they are already registered and settled during SELECT.
    always_comb begin
        idx_n = idx;
        if (state == IDLE && i_start) begin
            idx_n = '0;
        end else if (state == NEXT && state_n == SELECT) begin
            idx_n = idx + IW'(1);
        end
    end

    always_comb begin
        reg_off = idx_n - REG_BASE;
        mem_off = idx_n - MEM_BASE;
        addr_r  = '0;
        addr_m  = '0;
        if (idx_n >= REG_BASE && idx_n < MEM_BASE) begin
            addr_r = reg_off[AR-1:0];
        end
        if (idx_n >= MEM_BASE) begin
            addr_m = mem_off[AM-1:0];
        end
    end

    always_comb begin
        if (idx == '0) begin
            src = i_pc;
        end else if (idx == IW'(1)) begin
            src = i_clk_count;
        end else if (idx < MEM_BASE) begin
            src = i_data_register;
        end else begin
            src = i_data_mem;
        end
    end

    // Output logic: values the output registers take on the next edge
    always_comb begin
        tx_start_n = (state_n == SEND);
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE);
        tx_data_n  = o_tx_data;
        sel_r_n    = o_select_addr_registers;
        sel_m_n    = o_select_addr_memdata;
        if (state == LOAD) begin
            tx_data_n = src[SIZE_TRAMA-1:0];
        end else if (state == NEXT && state_n == SEND) begin
            // shift still holds the byte just sent in its low slot
            tx_data_n = shift[2*SIZE_TRAMA-1:SIZE_TRAMA];
        end
        if (state_n == SELECT) begin
            sel_r_n = addr_r;
            sel_m_n = addr_m;
        end else if (state_n == IDLE) begin
            sel_r_n = '0;
            sel_m_n = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx      <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            idx <= idx_n;
            if (state == LOAD) begin
                shift    <= src;
                byte_cnt <= '0;
            end else if (state == NEXT) begin
                shift    <= shift >> SIZE_TRAMA;
                byte_cnt <= byte_cnt + BW'(1);
            end else if (state == IDLE && i_start) begin
                byte_cnt <= '0;
            end
        end
    end

    // Output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_tx_start              <= 1'b0;
            o_tx_data               <= '0;
            o_busy                  <= 1'b0;
            o_done                  <= 1'b0;
            o_select_addr_registers <= '0;
            o_select_addr_memdata   <= '0;
        end else begin
            o_tx_start              <= tx_start_n;
            o_tx_data               <= tx_data_n;
            o_busy                  <= busy_n;
            o_done                  <= done_n;
            o_select_addr_registers <= sel_r_n;
            o_select_addr_memdata   <= sel_m_n;
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: directed bench for debug_dump_sequencer with a
// UART done-pulse model, frame capture and a table of expected frames.
module tb_debug_dump_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_pc;
    logic [31:0] i_clk_count;
    logic [31:0] i_data_register;
    logic [31:0] i_data_mem;
    logic        i_tx_done;
    logic [4:0]  o_select_addr_registers;
    logic [3:0]  o_select_addr_memdata;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    logic        uart_done;
    logic        force_done;
    logic        rand_mode;
    logic        stop_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nframes = 0;
    int ndone = 0;
    int done_cyc = 0;
    logic [7:0] frames [0:255];
    int         fcyc   [0:255];
    logic       pending = 1'b0;
    logic       prev_start = 1'b0;
    logic [7:0] held = 8'h00;

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [0:17];

    debug_dump_sequencer dut (
        .i_clk                   (i_clk),
        .i_reset                 (i_reset),
        .i_start                 (i_start),
        .i_pc                    (i_pc),
        .i_clk_count             (i_clk_count),
        .i_data_register         (i_data_register),
        .i_data_mem              (i_data_mem),
        .i_tx_done               (i_tx_done),
        .o_select_addr_registers (o_select_addr_registers),
        .o_select_addr_memdata   (o_select_addr_memdata),
        .o_tx_start              (o_tx_start),
        .o_tx_data               (o_tx_data),
        .o_busy                  (o_busy),
        .o_done                  (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    assign i_tx_done = uart_done | force_done;

    always_comb begin
        i_data_register = 32'(o_select_addr_registers) * 32'h0101_0101;
        i_data_mem      = 32'hA000_0000 + 32'(o_select_addr_memdata);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // UART model: done pulse a fixed or random number of cycles after start
    initial begin
        int d;
        uart_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                d = rand_mode ? int'($urandom_range(1, 50)) : 20;
                repeat (d) @(negedge i_clk);
                uart_done = 1'b1;
                @(negedge i_clk);
                uart_done = 1'b0;
            end
        end
    end

    // Frame monitor and handshake checks
    always @(posedge i_clk) begin
        #1;
        cyc++;
        if (i_reset) begin
            pending    = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (i_tx_done) pending = 1'b0;
            if (o_tx_start) begin
                chk("start_after_done", pending, 0);
                chk("start_not_back2back", prev_start, 0);
                if (nframes < 256) begin
                    frames[nframes] = o_tx_data;
                    fcyc[nframes]   = cyc;
                end
                nframes++;
                held    = o_tx_data;
                pending = 1'b1;
            end else if (pending) begin
                chk("data_stable", o_tx_data, held);
            end
            if (o_done) begin
                ndone++;
                done_cyc = cyc;
            end
            prev_start = o_tx_start;
        end
    end

    task automatic check_zero(input string p);
        chk({p, "_busy"}, o_busy, 0);
        chk({p, "_done"}, o_done, 0);
        chk({p, "_tx_start"}, o_tx_start, 0);
        chk({p, "_tx_data"}, o_tx_data, 0);
        chk({p, "_addr_reg"}, o_select_addr_registers, 0);
        chk({p, "_addr_mem"}, o_select_addr_memdata, 0);
    endtask

    task automatic pulse_start;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (!o_done && n < bound) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("done_seen", o_done, 1);
    endtask

    task automatic wait_frames(input int target, input int bound);
        int n;
        n = 0;
        while (nframes < target && n < bound) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("frames_reached", nframes >= target, 1);
    endtask

    task automatic check_table(input string p);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("%s_frame%0d", p, tbl[i].idx),
                frames[tbl[i].idx], tbl[i].exp);
        end
    endtask

    initial begin
        tbl[0]  = '{0,   8'h10};
        tbl[1]  = '{1,   8'h00};
        tbl[2]  = '{2,   8'h00};
        tbl[3]  = '{3,   8'h00};
        tbl[4]  = '{4,   8'h2A};
        tbl[5]  = '{5,   8'h00};
        tbl[6]  = '{6,   8'h00};
        tbl[7]  = '{7,   8'h00};
        tbl[8]  = '{20,  8'h03};
        tbl[9]  = '{21,  8'h03};
        tbl[10] = '{22,  8'h03};
        tbl[11] = '{23,  8'h03};
        tbl[12] = '{132, 8'h1F};
        tbl[13] = '{136, 8'h00};
        tbl[14] = '{139, 8'hA0};
        tbl[15] = '{196, 8'h0F};
        tbl[16] = '{198, 8'h00};
        tbl[17] = '{199, 8'hA0};

        i_reset     = 1'b1;
        i_start     = 1'b0;
        force_done  = 1'b0;
        rand_mode   = 1'b0;
        stop_pulse  = 1'b0;
        i_pc        = 32'h0000_0010;
        i_clk_count = 32'h0000_002A;

        // Reset state, then stray i_tx_done while idle
        #3;
        check_zero("por");
        repeat (2) @(negedge i_clk);
        i_reset    = 1'b0;
        force_done = 1'b1;
        repeat (10) begin
            @(posedge i_clk);
            #1;
            chk("idle_busy", o_busy, 0);
            chk("idle_tx_start", o_tx_start, 0);
        end
        @(negedge i_clk);
        force_done = 1'b0;

        // Full dump, fixed 20-cycle UART, with start-up timing
        nframes = 0;
        ndone   = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        chk("select_busy", o_busy, 1);
        chk("select_tx_start", o_tx_start, 0);
        @(negedge i_clk);
        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        chk("load_tx_start", o_tx_start, 0);
        @(posedge i_clk);
        #1;
        chk("send_tx_start", o_tx_start, 1);
        chk("send_tx_data", o_tx_data, 8'h10);
        wait_done(20000);
        repeat (3) @(posedge i_clk);
        #1;
        chk("full_busy_after", o_busy, 0);
        chk("full_nframes", nframes, 200);
        chk("full_ndone", ndone, 1);
        chk("gap_in_word", fcyc[1] - fcyc[0], 22);
        chk("gap_across_word", fcyc[4] - fcyc[3], 24);
        chk("last_to_done", done_cyc - fcyc[199], 22);
        check_table("full");

        // Random pacing with i_start hammered every 5 cycles
        nframes    = 0;
        ndone      = 0;
        rand_mode  = 1'b1;
        stop_pulse = 1'b0;
        pulse_start();
        fork
            begin
                while (!stop_pulse) begin
                    repeat (5) @(negedge i_clk);
                    if (!stop_pulse) begin
                        i_start = 1'b1;
                        @(negedge i_clk);
                        i_start = 1'b0;
                    end
                end
            end
        join_none
        wait_done(30000);
        stop_pulse = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        chk("rand_busy_after", o_busy, 0);
        chk("rand_nframes", nframes, 200);
        chk("rand_ndone", ndone, 1);
        check_table("rand");

        // Abort mid-dump with an asynchronous reset
        rand_mode = 1'b0;
        nframes   = 0;
        ndone     = 0;
        pulse_start();
        wait_frames(38, 5000);
        @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check_zero("abort");
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (60) @(posedge i_clk);
        #1;
        chk("abort_no_done", ndone, 0);
        chk("abort_busy", o_busy, 0);

        // Restart from the PC; change i_pc after it was captured
        nframes = 0;
        pulse_start();
        wait_frames(1, 20);
        chk("restart_frame0", frames[0], 8'h10);
        i_pc = 32'hDEAD_BEEF;
        wait_done(20000);
        repeat (3) @(posedge i_clk);
        #1;
        chk("capt_frame1", frames[1], 8'h00);
        chk("capt_frame2", frames[2], 8'h00);
        chk("capt_frame3", frames[3], 8'h00);
        chk("restart_nframes", nframes, 200);
        chk("restart_ndone", ndone, 1);
        i_pc = 32'h0000_0010;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
